// File: rtl/dmem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared size codes, FSM state type and lane/extension helpers
//           for the data-memory controller.
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Access size codes as presented on size_i
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Who owns the RAM: the CPU (RUN) or the UART programmer (LOAD)
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Byte-enable pattern for an access, already shifted to its lane offset.
    // Sized for the widest (64-bit) word; narrower users take the low lanes.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    // Sign/zero extension of right-aligned load data to 64 bits
    function automatic logic [63:0] extend(input logic [63:0] data, input logic [1:0] size,
                                           input logic is_unsigned);
        logic [63:0] r;
        case (size)
            SZ_B:    r = is_unsigned ? {56'b0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
            SZ_H:    r = is_unsigned ? {48'b0, data[15:0]} : {{48{data[15]}}, data[15:0]};
            SZ_W:    r = is_unsigned ? {32'b0, data[31:0]} : {{32{data[31]}}, data[31:0]};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dmem_bank
// Brief   : Single-port synchronous RAM with per-byte write enables and
//           write-first read port.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_bank #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 14,
    parameter int LANES     = DATA_W / 8,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] w_merged;

    // Word as it will look after this cycle's write (write-first read data)
    always_comb begin
        w_merged = r_mem[addr];
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) w_merged[i*8 +: 8] = din[i*8 +: 8];
        end
    end

    // Byte-lane writes and registered read
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) r_mem[addr][i*8 +: 8] <= din[i*8 +: 8];
        end
        dout <= w_merged;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dmem_ctrl
// Brief   : Data memory controller: byte/half/word(/dword) CPU access with
//           alignment check and extension, plus UART program-load arbitration.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 14,
    parameter     INIT_FILE = "",
    localparam int LANES    = DATA_W / 8,
    localparam int OFF_W    = $clog2(LANES)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [1:0]              size_i,
    input  logic                    unsigned_i,
    input  logic [ADDR_W+OFF_W-1:0] addr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    output logic                    ready_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    rvalid_o,
    output logic                    err_o,
    input  logic                    upg_wen_i,
    input  logic [ADDR_W-1:0]       upg_adr_i,
    input  logic [DATA_W-1:0]       upg_dat_i,
    input  logic                    upg_done_i,
    output logic                    load_act_o,
    output logic [ADDR_W:0]         load_cnt_o
);

    state_t              r_state, w_state_nxt;
    logic [OFF_W-1:0]    w_off;
    logic [ADDR_W-1:0]   w_waddr;
    logic                w_legal, w_accept, w_cpu_we, w_cpu_rd, w_cpu_err;
    logic [7:0]          w_mask8;
    logic [DATA_W-1:0]   w_wshift;
    logic [LANES-1:0]    w_bank_we;
    logic [ADDR_W-1:0]   w_bank_addr;
    logic [DATA_W-1:0]   w_bank_din, w_bank_dout;
    logic [DATA_W-1:0]   w_rd_shift, w_rdata_ext;
    logic [63:0]         w_ext64;
    logic                r_rd_vld, r_err, r_uns;
    logic [OFF_W-1:0]    r_off;
    logic [1:0]          r_size;
    logic [DATA_W-1:0]   r_rdata_hold;
    logic [ADDR_W:0]     r_load_cnt;

    assign w_off     = addr_i[OFF_W-1:0];
    assign w_waddr   = addr_i[ADDR_W+OFF_W-1:OFF_W];
    assign w_accept  = req_i && (r_state == RUN);
    assign w_cpu_we  = w_accept && w_legal && we_i;
    assign w_cpu_rd  = w_accept && w_legal && !we_i;
    assign w_cpu_err = w_accept && !w_legal;
    assign w_mask8   = lane_mask(size_i, 3'(w_off));
    assign w_wshift  = wdata_i << {w_off, 3'b000};

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: upload busy grabs the RAM; leave once idle with no write pending
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (!upg_done_i) w_state_nxt = LOAD;
            LOAD:    if (upg_done_i && !upg_wen_i) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    assign ready_o    = (r_state == RUN);
    assign load_act_o = (r_state == LOAD);
    assign load_cnt_o = r_load_cnt;

    // Alignment rules per access size; dword only exists on a 64-bit datapath
    always_comb begin
        w_legal = 1'b0;
        case (size_i)
            SZ_B:    w_legal = 1'b1;
            SZ_H:    w_legal = !w_off[0];
            SZ_W:    w_legal = (w_off[1:0] == 2'b00);
            default: w_legal = (DATA_W == 64) && (w_off == '0);
        endcase
    end

    // RAM port mux: the loader owns the port in LOAD, the CPU otherwise
    always_comb begin
        w_bank_we   = '0;
        w_bank_addr = w_waddr;
        w_bank_din  = w_wshift;
        if (r_state == LOAD) begin
            w_bank_addr = upg_adr_i;
            w_bank_din  = upg_dat_i;
            if (upg_wen_i) w_bank_we = '1;
        end else if (w_cpu_we) begin
            w_bank_we = w_mask8[LANES-1:0];
        end
    end

    dmem_bank #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .LANES     (LANES),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk  (clk_i),
        .we   (w_bank_we),
        .addr (w_bank_addr),
        .din  (w_bank_din),
        .dout (w_bank_dout)
    );

    // Read-align and extend using the attributes captured at acceptance
    assign w_rd_shift  = w_bank_dout >> {r_off, 3'b000};
    assign w_ext64     = extend(64'(w_rd_shift), r_size, r_uns);
    assign w_rdata_ext = w_ext64[DATA_W-1:0];
    assign rdata_o     = r_rd_vld ? w_rdata_ext : r_rdata_hold;
    assign rvalid_o    = r_rd_vld;
    assign err_o       = r_err;

    if (DATA_W < 64) begin : g_narrow
        logic w_unused_hi;
        assign w_unused_hi = ^{w_ext64[63:DATA_W], w_mask8[7:LANES]};
    end

    // Response stage: pulse flags, load attributes and held read data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_vld     <= 1'b0;
            r_err        <= 1'b0;
            r_off        <= '0;
            r_size       <= SZ_B;
            r_uns        <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_rd_vld <= w_cpu_rd;
            r_err    <= w_cpu_err;
            if (w_cpu_rd) begin
                r_off  <= w_off;
                r_size <= size_i;
                r_uns  <= unsigned_i;
            end
            if (r_rd_vld) r_rdata_hold <= w_rdata_ext;
        end
    end

    // Upload word counter: cleared on entry to LOAD, saturates once the top bit sets
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_load_cnt <= '0;
        end else if (r_state == RUN) begin
            if (!upg_done_i) r_load_cnt <= '0;
        end else if (upg_wen_i && !r_load_cnt[ADDR_W]) begin
            r_load_cnt <= r_load_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
